// File: rtl/writeback_unit.sv
// writeback_unit: Y86-64 write-back stage and program register file.
//   Latches one retiring instruction per cycle into the W-stage register,
//   deriving dstE/dstM and the instruction status at capture. On the next
//   edge it commits valE/valM into the register file and tracks the sticky
//   processor status.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall, bubble               W-stage hold / nop insertion (stall wins)
//   instructionValid, icode,    retiring instruction fields
//   rA, rB, cnd, dmem_error
//   valE, valM                  ALU and memory results
//   w_dstE/w_dstM/w_valE/w_valM W-stage contents for decode forwarding
//   stat, halted                status (1 AOK, 2 HLT, 3 ADR, 4 INS), stat != AOK
//   register0..register14       program register observation
module writeback_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             bubble,
  input  logic             instructionValid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic             dmem_error,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [3:0]       w_dstE,
  output logic [3:0]       w_dstM,
  output logic [WIDTH-1:0] w_valE,
  output logic [WIDTH-1:0] w_valM,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [WIDTH-1:0] register0,
  output logic [WIDTH-1:0] register1,
  output logic [WIDTH-1:0] register2,
  output logic [WIDTH-1:0] register3,
  output logic [WIDTH-1:0] register4,
  output logic [WIDTH-1:0] register5,
  output logic [WIDTH-1:0] register6,
  output logic [WIDTH-1:0] register7,
  output logic [WIDTH-1:0] register8,
  output logic [WIDTH-1:0] register9,
  output logic [WIDTH-1:0] register10,
  output logic [WIDTH-1:0] register11,
  output logic [WIDTH-1:0] register12,
  output logic [WIDTH-1:0] register13,
  output logic [WIDTH-1:0] register14
);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  logic [3:0]       cap_dstE, cap_dstM;
  stat_e            cap_stat;

  logic [3:0]       w_dstE_q, w_dstE_d;
  logic [3:0]       w_dstM_q, w_dstM_d;
  logic [WIDTH-1:0] w_valE_q, w_valE_d;
  logic [WIDTH-1:0] w_valM_q, w_valM_d;
  stat_e            w_stat_q, w_stat_d;

  stat_e            stat_q;
  logic [WIDTH-1:0] rf_q [NREG];

  // Destination and status decode of the instruction being captured.
  always_comb begin
    cap_dstE = REG_NONE;
    cap_dstM = REG_NONE;
    cap_stat = STAT_AOK;
    case (icode)
      4'h2:                   if (cnd) cap_dstE = rB;
      4'h3, 4'h6:             cap_dstE = rB;
      4'h8, 4'h9, 4'hA, 4'hB: cap_dstE = REG_RSP;
      default: ;
    endcase
    if (icode == 4'h5 || icode == 4'hB) cap_dstM = rA;
    if (!instructionValid || icode > 4'hB) cap_stat = STAT_INS;
    else if (dmem_error)                   cap_stat = STAT_ADR;
    else if (icode == 4'h0)                cap_stat = STAT_HLT;
  end

  // W-stage next state; frozen once the processor has left AOK.
  always_comb begin
    w_dstE_d = w_dstE_q;
    w_dstM_d = w_dstM_q;
    w_valE_d = w_valE_q;
    w_valM_d = w_valM_q;
    w_stat_d = w_stat_q;
    if (!halted && !stall) begin
      if (bubble) begin
        w_dstE_d = REG_NONE;
        w_dstM_d = REG_NONE;
        w_stat_d = STAT_AOK;
      end else begin
        w_dstE_d = cap_dstE;
        w_dstM_d = cap_dstM;
        w_valE_d = valE;
        w_valM_d = valM;
        w_stat_d = cap_stat;
      end
    end
  end

  // W-stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_dstE_q <= REG_NONE;
      w_dstM_q <= REG_NONE;
      w_valE_q <= '0;
      w_valM_q <= '0;
      w_stat_q <= STAT_AOK;
    end else begin
      w_dstE_q <= w_dstE_d;
      w_dstM_q <= w_dstM_d;
      w_valE_q <= w_valE_d;
      w_valM_q <= w_valM_d;
      w_stat_q <= w_stat_d;
    end
  end

  // Register file commit; the M write is issued last so it wins on dstE==dstM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (!halted && w_stat_q == STAT_AOK) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (w_dstE_q == 4'(i)) rf_q[i] <= w_valE_q;
        if (w_dstM_q == 4'(i)) rf_q[i] <= w_valM_q;
      end
    end
  end

  // Sticky status: the first faulting W entry sets it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= STAT_AOK;
    end else if (!halted && w_stat_q != STAT_AOK) begin
      stat_q <= w_stat_q;
    end
  end

  assign halted = (stat_q != STAT_AOK);
  assign stat   = stat_q;
  assign w_dstE = w_dstE_q;
  assign w_dstM = w_dstM_q;
  assign w_valE = w_valE_q;
  assign w_valM = w_valM_q;

  assign register0  = rf_q[0];
  assign register1  = rf_q[1];
  assign register2  = rf_q[2];
  assign register3  = rf_q[3];
  assign register4  = rf_q[4];
  assign register5  = rf_q[5];
  assign register6  = rf_q[6];
  assign register7  = rf_q[7];
  assign register8  = rf_q[8];
  assign register9  = rf_q[9];
  assign register10 = rf_q[10];
  assign register11 = rf_q[11];
  assign register12 = rf_q[12];
  assign register13 = rf_q[13];
  assign register14 = rf_q[14];

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios plus random traffic
// against an instruction-level model of the write-back stage.
module tb_writeback_unit;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic stall = 1'b0, bubble = 1'b1, instructionValid = 1'b1, cnd = 1'b0, dmem_error = 1'b0;
  logic [3:0] icode = 4'h1, rA = 4'hF, rB = 4'hF;
  logic [W-1:0] valE = '0, valM = '0;
  logic [3:0] w_dstE, w_dstM;
  logic [W-1:0] w_valE, w_valM;
  logic [2:0] stat;
  logic halted;
  logic [W-1:0] register0, register1, register2, register3, register4, register5,
                register6, register7, register8, register9, register10, register11,
                register12, register13, register14;
  logic [15*W-1:0] dut_regs;

  assign dut_regs = {register14, register13, register12, register11, register10,
                     register9, register8, register7, register6, register5,
                     register4, register3, register2, register1, register0};

  writeback_unit #(.WIDTH(W), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .instructionValid(instructionValid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .dmem_error(dmem_error), .valE(valE), .valM(valM),
    .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
    .stat(stat), .halted(halted),
    .register0(register0), .register1(register1), .register2(register2),
    .register3(register3), .register4(register4), .register5(register5),
    .register6(register6), .register7(register7), .register8(register8),
    .register9(register9), .register10(register10), .register11(register11),
    .register12(register12), .register13(register13), .register14(register14)
  );

  typedef struct packed {
    logic [3:0]      dE;
    logic [3:0]      dM;
    logic [W-1:0]    vE;
    logic [W-1:0]    vM;
    logic [2:0]      st;
    logic [15*W-1:0] rf;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: architectural registers, the one retiring instruction
  // sitting in write-back, and the processor status.
  logic [W-1:0] m_rf [15];
  logic [3:0]   m_wE, m_wM;
  logic [W-1:0] m_wvE, m_wvM;
  logic [2:0]   m_wst, m_st;

  function automatic logic [3:0] ref_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [2:0] ref_stat(input logic iv, input logic [3:0] ic, input logic de);
    if (!iv || ic > 4'hB) return 3'd4;
    if (de) return 3'd3;
    if (ic == 4'h0) return 3'd2;
    return 3'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_rf[i] = '0;
    m_wE = 4'hF; m_wM = 4'hF; m_wvE = '0; m_wvM = '0; m_wst = 3'd1; m_st = 3'd1;
  endtask

  // One edge: retire the instruction in write-back, then accept the next one.
  task automatic model_edge(input logic st, input logic bu, input logic iv, input logic [3:0] ic,
                            input logic [3:0] ra, input logic [3:0] rb, input logic c,
                            input logic de, input logic [W-1:0] ve, input logic [W-1:0] vm);
    if (m_st != 3'd1) return;
    if (m_wst == 3'd1) begin
      if (m_wE != 4'hF) m_rf[m_wE] = m_wvE;
      if (m_wM != 4'hF) m_rf[m_wM] = m_wvM;
    end else begin
      m_st = m_wst;
    end
    if (st) return;
    if (bu) begin
      m_wE = 4'hF; m_wM = 4'hF; m_wst = 3'd1;
    end else begin
      m_wE = ref_dstE(ic, rb, c); m_wM = ref_dstM(ic, ra);
      m_wvE = ve; m_wvM = vm; m_wst = ref_stat(iv, ic, de);
    end
  endtask

  task automatic apply(input logic st, input logic bu, input logic iv, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb, input logic c,
                       input logic de, input logic [W-1:0] ve, input logic [W-1:0] vm);
    exp_t e;
    @(negedge clk);
    stall = st; bubble = bu; instructionValid = iv; icode = ic; rA = ra; rB = rb;
    cnd = c; dmem_error = de; valE = ve; valM = vm;
    model_edge(st, bu, iv, ic, ra, rb, c, de, ve, vm);
    e.dE = m_wE; e.dM = m_wM; e.vE = m_wvE; e.vM = m_wvM; e.st = m_st;
    for (int i = 0; i < 15; i++) e.rf[i*W +: W] = m_rf[i];
    exp_q.push_back(e);
  endtask

  task automatic ins(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                     input logic c, input logic [W-1:0] ve, input logic [W-1:0] vm);
    apply(1'b0, 1'b0, 1'b1, ic, ra, rb, c, 1'b0, ve, vm);
  endtask

  // Mid-cycle asynchronous reset with an immediate check of the reset state.
  task automatic do_reset();
    logic [W-1:0] r;
    @(negedge clk);
    stall = 1'b0; bubble = 1'b1; icode = 4'h1; instructionValid = 1'b1; dmem_error = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stat", W'(stat), W'(1));
    chk("rst_halted", W'(halted), W'(0));
    chk("rst_w_dstE", W'(w_dstE), W'(4'hF));
    chk("rst_w_dstM", W'(w_dstM), W'(4'hF));
    chk("rst_w_valE", w_valE, '0);
    chk("rst_w_valM", w_valM, '0);
    for (int i = 0; i < 15; i++) begin
      r = dut_regs[i*W +: W];
      chk($sformatf("rst_reg%0d", i), r, '0);
    end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic post_edge_check();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    logic [W-1:0] a, x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w_dstE", W'(w_dstE), W'(e.dE));
        chk("w_dstM", W'(w_dstM), W'(e.dM));
        if (e.dE != 4'hF) chk("w_valE", w_valE, e.vE);
        if (e.dM != 4'hF) chk("w_valM", w_valM, e.vM);
        chk("stat", W'(stat), W'(e.st));
        chk("halted", W'(halted), W'(e.st != 3'd1));
        for (int i = 0; i < 15; i++) begin
          a = dut_regs[i*W +: W];
          x = e.rf[i*W +: W];
          chk($sformatf("reg%0d", i), a, x);
        end
      end
    end
  end

  initial begin
    logic [3:0] ic;
    int cyc;
    model_reset();
    do_reset();

    // irmovq then a not-taken cmov.
    ins(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
    post_edge_check();
    chk("irmovq_w_dstE", W'(w_dstE), W'(4'h2));
    ins(4'h2, 4'h3, 4'h1, 1'b0, 64'h5555, 64'h0);
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    post_edge_check();
    chk("irmovq_reg2", register2, 64'h1234);
    chk("cmov_nt_reg1", register1, 64'h0);

    // popq %rsp: M write wins; then popq %rbx.
    ins(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hBEEF);
    ins(4'hB, 4'h3, 4'hF, 1'b0, 64'h200, 64'hCAFE);
    post_edge_check();
    chk("popq_rsp_reg4", register4, 64'hBEEF);
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    post_edge_check();
    chk("popq2_reg4", register4, 64'h200);
    chk("popq2_reg3", register3, 64'hCAFE);

    // Stall beats bubble; bubble alone inserts a nop.
    ins(4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0);
    apply(1'b1, 1'b1, 1'b1, 4'h3, 4'hF, 4'h8, 1'b0, 1'b0, 64'h88, 64'h0);
    post_edge_check();
    chk("stall_w_dstE", W'(w_dstE), W'(4'h7));
    apply(1'b0, 1'b1, 1'b1, 4'h3, 4'hF, 4'h8, 1'b0, 1'b0, 64'h99, 64'h0);
    post_edge_check();
    chk("bubble_w_dstE", W'(w_dstE), W'(4'hF));
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    post_edge_check();
    chk("bubble_reg8", register8, 64'h0);
    chk("stall_reg7", register7, 64'h77);

    // Halt: following irmovq never commits; status sticks.
    ins(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    ins(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0);
    post_edge_check();
    chk("halt_stat", W'(stat), W'(2));
    chk("halt_halted", W'(halted), W'(1));
    for (int i = 0; i < 3; i++) ins(4'h3, 4'hF, 4'h5, 1'b0, 64'h66, 64'h0);
    post_edge_check();
    chk("halt_reg5", register5, 64'h0);
    chk("halt_sticky", W'(stat), W'(2));
    do_reset();

    // Invalid instruction and data-memory fault.
    apply(1'b0, 1'b0, 1'b0, 4'h6, 4'h1, 4'h2, 1'b0, 1'b0, 64'h11, 64'h0);
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    post_edge_check();
    chk("ins_stat", W'(stat), W'(4));
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 4'h5, 4'h6, 4'hF, 1'b0, 1'b1, 64'h40, 64'hDEAD);
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    ins(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    post_edge_check();
    chk("adr_stat", W'(stat), W'(3));
    chk("adr_reg6", register6, 64'h0);
    do_reset();

    // Random traffic, resetting a while after the model halts.
    cyc = 0;
    for (int n = 0; n < 2500; n++) begin
      if (m_st != 3'd1 && ($urandom % 4 == 0)) begin
        do_reset();
      end else begin
        ic = ($urandom % 30 == 0) ? 4'($urandom % 16) : 4'($urandom_range(1, 11));
        apply(($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 60) != 0, ic,
              4'($urandom % 16), 4'($urandom % 16), 1'($urandom % 2),
              ($urandom % 50) == 0, {$urandom, $urandom}, {$urandom, $urandom});
      end
      cyc++;
    end

    post_edge_check();
    post_edge_check();
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
